time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Button-driven controller that lets the user edit local hours and minutes of the running posix time watches and commits the result through the watches' user posix time load interface. It sits between the debounced button pulses and the posix time watches block. It takes a consistent mid-second snapshot of the current time, runs a hour→minute edit sequence with wrap-around, aborts on inactivity, and emits exactly one load pulse per completed edit.

Parameters:
CONV_LAT, 2, cycles from a posix_time_i change to the matching hour_i/min_i/sec_i (posix-to-time pipeline latency)
TIMEOUT_SEC, 30, seconds (tick_i pulses) without a button press before the edit is aborted

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
mode_btn_i  input  1  one-cycle debounced pulse: enter edit / next field / commit
inc_btn_i  input  1  one-cycle pulse: increment current field
dec_btn_i  input  1  one-cycle pulse: decrement current field
tick_i  input  1  one-cycle pulse at each second boundary (watches last tick)
posix_time_i  input  32  current posix time from watches
hour_i  input  5  current local hour, 0..23
min_i  input  6  current minute, 0..59
sec_i  input  6  current second, 0..59
user_posix_time_o  output  32  value to load into watches
user_posix_time_en_o  output  1  one-cycle load strobe
edit_active_o  output  1  high in any state except IDLE
edit_field_o  output  2  0 none, 1 hour, 2 minute
edit_hour_o  output  5  hour value being edited
edit_min_o  output  6  minute value being edited

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high. All state is registered on clk_i.
- Reset values: state IDLE; all outputs 0; internal snapshot registers, timeout counter and settle counter 0.
- States: IDLE, SYNC, SETTLE, SET_HOUR, SET_MIN, COMMIT.
- IDLE: mode pulse → SYNC. inc/dec are ignored.
- SYNC: wait for tick_i → SETTLE, with settle counter cleared.
- SETTLE: count CONV_LAT+1 cycles, then snapshot and go to SET_HOUR.
  - This guarantees posix_time_i and hour/min/sec are coherent and at least half a second away from the next tick for any realistic clock rate.
  - Snapshot: day_base = posix_time_i − (hour_i·3600 + min_i·60 + sec_i), 32-bit unsigned wrap arithmetic.
  - Also at snapshot: edit_hour = hour_i, edit_min = min_i.
  - mode/inc/dec are ignored in SYNC and SETTLE.
- SET_HOUR, edit_field_o=1:
  - inc: edit_hour+1, 23 wraps to 0.
  - dec: edit_hour−1, 0 wraps to 23.
  - mode → SET_MIN.
- SET_MIN, edit_field_o=2:
  - inc: edit_min+1, 59 wraps to 0.
  - dec: edit_min−1, 0 wraps to 59.
  - mode → COMMIT.
- Mode accepted in SET_MIN at cycle N:
  - user_posix_time_o is registered at N with day_base + edit_hour·3600 + edit_min·60; seconds are forced to 0.
  - State is COMMIT at N+1, with user_posix_time_en_o=1 for exactly that one cycle.
  - State is IDLE at N+2. user_posix_time_o holds its value until the next commit.
- Simultaneous events:
  - mode with inc/dec in the same cycle: mode wins, inc/dec are dropped.
  - inc and dec in the same cycle: both are ignored.
- Timeout:
  - In SET_HOUR/SET_MIN, the counter increments on each tick_i and clears on any mode/inc/dec pulse (including ignored inc+dec pairs).
  - When the counter reaches TIMEOUT_SEC: go to IDLE, no strobe, edit_field_o=0.
  - If a button press and a tick arrive in the same cycle, the counter is cleared.
- Timeout in SYNC/SETTLE does not apply; the tick is free-running.
- Reset mid-operation: IDLE next cycle; no strobe is ever emitted for a partial edit.
- Outputs in IDLE:
  - edit_active_o = 0.
  - edit_field_o = 0.
  - edit_hour_o/edit_min_o hold their last values.
- Arithmetic: the hour·3600 and min·60 products are computed at ≥17 bits and zero-extended to 32. Combinational multiply or shift-add, all within one cycle.

Test Plan:
- Nominal edit: posix_time_i=1000, hour_i=0, min_i=16, sec_i=40 (coherent with CONV_LAT); mode, then tick, then 2× inc, mode, 1× dec, mode → user_posix_time_o=8100, en high exactly 1 cycle, 1 cycle after the last mode; then IDLE.
- Wrap: snapshot hour 23/min 0; inc hour → 0; dec min → 59; commit → day_base + 3540.
- Timeout: TIMEOUT_SEC=10; enter SET_HOUR, issue 10 ticks with no buttons → IDLE, en never asserted. Repeat with an inc at tick 9 → still in SET_HOUR after tick 10.
- Simultaneous: inc+dec in the same cycle leaves edit_hour unchanged. mode+inc in SET_HOUR → SET_MIN with edit_hour unchanged.
- Snapshot timing: mode pulse between ticks → no snapshot until tick + CONV_LAT+1 cycles. inc pulses during SYNC/SETTLE have no effect.
- Reset: assert rst_i while in SET_MIN → all outputs 0 next cycle, no strobe; a subsequent full edit works normally.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Button-driven hour/minute editor for the posix time watches: snapshots the
// running time just after a second boundary, edits it, and loads it back once.
module time_set_ctrl #(
    parameter int CONV_LAT    = 2,
    parameter int TIMEOUT_SEC = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mode_btn_i,
    input  logic        inc_btn_i,
    input  logic        dec_btn_i,
    input  logic        tick_i,
    input  logic [31:0] posix_time_i,
    input  logic [4:0]  hour_i,
    input  logic [5:0]  min_i,
    input  logic [5:0]  sec_i,
    output logic [31:0] user_posix_time_o,
    output logic        user_posix_time_en_o,
    output logic        edit_active_o,
    output logic [1:0]  edit_field_o,
    output logic [4:0]  edit_hour_o,
    output logic [5:0]  edit_min_o
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SYNC     = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_SET_HOUR = 3'd3;
    localparam logic [2:0] S_SET_MIN  = 3'd4;
    localparam logic [2:0] S_COMMIT   = 3'd5;

    localparam int TW = (TIMEOUT_SEC < 2) ? 1 : $clog2(TIMEOUT_SEC + 1);
    localparam int SW = $clog2(CONV_LAT + 2);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_SEC - 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(CONV_LAT);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [31:0]   day_base_q, day_base_d;
    logic [31:0]   user_time_q, user_time_d;
    logic [4:0]    edit_hour_q, edit_hour_d;
    logic [5:0]    edit_min_q, edit_min_d;

    logic          any_btn;
    logic          single_step;
    logic [16:0]   cur_sod;
    logic [16:0]   edit_sod;
    logic [4:0]    hour_up, hour_dn;
    logic [5:0]    min_up, min_dn;

    assign any_btn     = mode_btn_i | inc_btn_i | dec_btn_i;
    assign single_step = inc_btn_i ^ dec_btn_i;

    // Seconds-of-day never exceed 86399, so 17 bits hold both sums exactly.
    assign cur_sod  = 17'(hour_i) * 17'd3600 + 17'(min_i) * 17'd60 + 17'(sec_i);
    assign edit_sod = 17'(edit_hour_q) * 17'd3600 + 17'(edit_min_q) * 17'd60;

    assign hour_up = (edit_hour_q == 5'd23) ? 5'd0  : edit_hour_q + 5'd1;
    assign hour_dn = (edit_hour_q == 5'd0)  ? 5'd23 : edit_hour_q - 5'd1;
    assign min_up  = (edit_min_q == 6'd59)  ? 6'd0  : edit_min_q + 6'd1;
    assign min_dn  = (edit_min_q == 6'd0)   ? 6'd59 : edit_min_q - 6'd1;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        timeout_d   = timeout_q;
        day_base_d  = day_base_q;
        user_time_d = user_time_q;
        edit_hour_d = edit_hour_q;
        edit_min_d  = edit_min_q;
        case (state_q)
            S_IDLE: begin
                if (mode_btn_i) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (tick_i) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    day_base_d  = posix_time_i - {15'd0, cur_sod};
                    edit_hour_d = hour_i;
                    edit_min_d  = min_i;
                    timeout_d   = '0;
                    state_d     = S_SET_HOUR;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SET_HOUR, S_SET_MIN: begin
                if (any_btn) begin
                    timeout_d = '0;
                end else if (tick_i) begin
                    if (timeout_q == TIMEOUT_LAST) begin
                        timeout_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        timeout_d = timeout_q + 1'b1;
                    end
                end
                // Mode takes priority; an inc+dec pair cancels out.
                if (mode_btn_i) begin
                    if (state_q == S_SET_HOUR) begin
                        state_d = S_SET_MIN;
                    end else begin
                        user_time_d = day_base_q + {15'd0, edit_sod};
                        state_d     = S_COMMIT;
                    end
                end else if (single_step) begin
                    if (state_q == S_SET_HOUR) edit_hour_d = inc_btn_i ? hour_up : hour_dn;
                    else                       edit_min_d  = inc_btn_i ? min_up  : min_dn;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            timeout_q   <= '0;
            day_base_q  <= '0;
            user_time_q <= '0;
            edit_hour_q <= '0;
            edit_min_q  <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            timeout_q   <= timeout_d;
            day_base_q  <= day_base_d;
            user_time_q <= user_time_d;
            edit_hour_q <= edit_hour_d;
            edit_min_q  <= edit_min_d;
        end
    end

    assign user_posix_time_o    = user_time_q;
    assign user_posix_time_en_o = (state_q == S_COMMIT);
    assign edit_active_o        = (state_q != S_IDLE);
    assign edit_field_o         = (state_q == S_SET_HOUR) ? 2'd1 :
                                  (state_q == S_SET_MIN)  ? 2'd2 : 2'd0;
    assign edit_hour_o          = edit_hour_q;
    assign edit_min_o           = edit_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a behavioural model driven by the bench's own notion
// of true time is compared every cycle, plus directed literal checks.
module tb_time_set_ctrl;
    localparam int CONV_LAT    = 2;
    localparam int TIMEOUT_SEC = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mode_btn_i = 1'b0;
    logic        inc_btn_i = 1'b0;
    logic        dec_btn_i = 1'b0;
    logic        tick_i = 1'b0;
    logic [31:0] posix_time_i = '0;
    logic [4:0]  hour_i = '0;
    logic [5:0]  min_i = '0;
    logic [5:0]  sec_i = '0;
    logic [31:0] user_posix_time_o;
    logic        user_posix_time_en_o;
    logic        edit_active_o;
    logic [1:0]  edit_field_o;
    logic [4:0]  edit_hour_o;
    logic [5:0]  edit_min_o;

    time_set_ctrl #(.CONV_LAT(CONV_LAT), .TIMEOUT_SEC(TIMEOUT_SEC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mode_btn_i(mode_btn_i), .inc_btn_i(inc_btn_i), .dec_btn_i(dec_btn_i),
        .tick_i(tick_i), .posix_time_i(posix_time_i),
        .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
        .user_posix_time_o(user_posix_time_o),
        .user_posix_time_en_o(user_posix_time_en_o),
        .edit_active_o(edit_active_o), .edit_field_o(edit_field_o),
        .edit_hour_o(edit_hour_o), .edit_min_o(edit_min_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;
    logic [31:0] t = '0;          // true posix time (UTC, zero zone offset)
    int          cycle_no = 0;
    int          tick_cyc = -100;
    int          en_count = 0;

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_WAIT = 1, P_SETTLE = 2, P_EDIT = 3, P_DONE = 4;
    int          m_phase = P_IDLE;
    int          m_field = 0;
    int          m_left = 0;
    int          m_quiet = 0;
    int          m_h = 0;
    int          m_m = 0;
    int          m_commits = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_user = '0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_phase <= P_IDLE; m_field <= 0; m_quiet <= 0;
            m_h <= 0; m_m <= 0; m_base <= '0; m_user <= '0;
        end else begin
            case (m_phase)
                P_IDLE: if (mode_btn_i) m_phase <= P_WAIT;
                P_WAIT: if (tick_i) begin m_phase <= P_SETTLE; m_left <= CONV_LAT + 1; end
                P_SETTLE: begin
                    if (m_left == 1) begin
                        m_base  <= t - (t % 32'd86400);
                        m_h     <= int'((t % 32'd86400) / 32'd3600);
                        m_m     <= int'((t % 32'd3600) / 32'd60);
                        m_phase <= P_EDIT; m_field <= 1; m_quiet <= 0;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                P_EDIT: begin
                    if (mode_btn_i) begin
                        m_quiet <= 0;
                        if (m_field == 1) m_field <= 2;
                        else begin
                            m_user    <= m_base + 32'(m_h * 3600 + m_m * 60);
                            m_phase   <= P_DONE;
                            m_commits <= m_commits + 1;
                        end
                    end else if (inc_btn_i || dec_btn_i) begin
                        m_quiet <= 0;
                        if (inc_btn_i != dec_btn_i) begin
                            if (m_field == 1) m_h <= (m_h + (inc_btn_i ? 1 : 23)) % 24;
                            else              m_m <= (m_m + (inc_btn_i ? 1 : 59)) % 60;
                        end
                    end else if (tick_i) begin
                        if (m_quiet + 1 >= TIMEOUT_SEC) begin m_phase <= P_IDLE; m_quiet <= 0; end
                        else m_quiet <= m_quiet + 1;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        if (chk_en) begin
            checks++;
            if (user_posix_time_en_o) en_count++;
            if (user_posix_time_en_o !== (m_phase == P_DONE) ||
                edit_active_o !== (m_phase != P_IDLE) ||
                edit_field_o !== 2'((m_phase == P_EDIT) ? m_field : 0) ||
                edit_hour_o !== 5'(m_h) || edit_min_o !== 6'(m_m) ||
                user_posix_time_o !== m_user) begin
                errors++;
                $display("FAIL model cycle %0d: got en=%0b act=%0b fld=%0d h=%0d m=%0d user=%0d, exp en=%0b act=%0b fld=%0d h=%0d m=%0d user=%0d",
                         cycle_no, user_posix_time_en_o, edit_active_o, edit_field_o,
                         edit_hour_o, edit_min_o, user_posix_time_o,
                         (m_phase == P_DONE), (m_phase != P_IDLE),
                         (m_phase == P_EDIT) ? m_field : 0, m_h, m_m, m_user);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_hms();
        hour_i = 5'((t % 32'd86400) / 32'd3600);
        min_i  = 6'((t % 32'd3600) / 32'd60);
        sec_i  = 6'(t % 32'd60);
    endtask

    task automatic set_time(input logic [31:0] v);
        t = v;
        posix_time_i = t;
        drive_hms();
    endtask

    // One clock cycle; the watches update posix one cycle after a tick and the
    // broken-down time CONV_LAT cycles after that.
    task automatic cyc(input logic md, input logic ic, input logic dc, input logic tk, input logic rs);
        @(negedge clk_i);
        cycle_no++;
        if (cycle_no == tick_cyc + 1) begin t = t + 32'd1; posix_time_i = t; end
        if (cycle_no == tick_cyc + 1 + CONV_LAT) drive_hms();
        rst_i = rs; mode_btn_i = md; inc_btn_i = ic; dec_btn_i = dc; tick_i = tk;
        if (tk) tick_cyc = cycle_no;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) begin cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); idle(4); end
    endtask

    task automatic enter_edit();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        logic md, ic, dc, tk, rs;
        int gap;
        bit quiet;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        check("reset_active", 32'(edit_active_o), 0);
        check("reset_user", user_posix_time_o, 0);
        check("reset_en", 32'(user_posix_time_en_o), 0);

        // nominal edit: 00:16:40 -> 02:15 on day 0
        set_time(32'd1000);
        enter_edit();
        check("nom_field", 32'(edit_field_o), 1);
        check("nom_hour", 32'(edit_hour_o), 0);
        check("nom_min", 32'(edit_min_o), 16);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); idle(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("nom_en", 32'(user_posix_time_en_o), 1);
        check("nom_user", user_posix_time_o, 32'd8100);
        idle(1);
        check("nom_en_off", 32'(user_posix_time_en_o), 0);
        check("nom_idle", 32'(edit_active_o), 0);
        check("nom_hold", user_posix_time_o, 32'd8100);

        // wrap: 23:00 on day 5 -> 00:59 same day
        set_time(32'd514807);
        enter_edit();
        check("wrap_hour_in", 32'(edit_hour_o), 23);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
        check("wrap_hour", 32'(edit_hour_o), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); idle(1);
        check("wrap_min", 32'(edit_min_o), 59);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(1);
        check("wrap_user", user_posix_time_o, 32'd435540);
        idle(2);

        // timeout after TIMEOUT_SEC silent seconds
        enter_edit();
        secs(TIMEOUT_SEC - 1);
        check("to_still_active", 32'(edit_active_o), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); idle(1);
        check("to_aborted", 32'(edit_active_o), 0);
        check("to_field", 32'(edit_field_o), 0);
        idle(4);

        // an inc together with tick 9 restarts the count
        enter_edit();
        secs(TIMEOUT_SEC - 2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); idle(4);
        secs(1);
        check("to_kept_active", 32'(edit_active_o), 1);
        check("to_kept_field", 32'(edit_field_o), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // simultaneous buttons
        enter_edit();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); idle(1);
        check("incdec_hour", 32'(edit_hour_o), (t % 32'd86400) / 32'd3600);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
        check("modeinc_field", 32'(edit_field_o), 2);
        check("modeinc_hour", 32'(edit_hour_o), (t % 32'd86400) / 32'd3600);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // snapshot timing with inc pulses during SYNC/SETTLE
        set_time(32'd7384);                       // 02:03:04
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
        check("sync_waiting", 32'(edit_field_o), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("settle_no_field", 32'(edit_field_o), 0);
        idle(1);
        check("snap_field", 32'(edit_field_o), 1);
        check("snap_hour", 32'(edit_hour_o), 2);
        check("snap_min", 32'(edit_min_o), 3);

        // reset while editing minutes
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(1);
        check("pre_rst_field", 32'(edit_field_o), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); idle(1);
        check("rst_active", 32'(edit_active_o), 0);
        check("rst_field", 32'(edit_field_o), 0);
        check("rst_hour", 32'(edit_hour_o), 0);
        check("rst_min", 32'(edit_min_o), 0);
        check("rst_user", user_posix_time_o, 0);
        check("rst_en", 32'(user_posix_time_en_o), 0);
        set_time(32'd1000);
        enter_edit();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("post_rst_user", user_posix_time_o, 32'd8100);
        idle(5);

        // randomized traffic with quiet windows to provoke timeouts
        set_time($urandom);
        gap = 0;
        quiet = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tk = (gap == 0);
            if (tk) gap = $urandom_range(5, 9);
            gap--;
            quiet = ((i / 400) % 3) == 2;
            md = !quiet && ($urandom_range(0, 11) == 0);
            ic = !quiet && ($urandom_range(0, 3) == 0);
            dc = !quiet && ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 999) == 0);
            cyc(md, ic, dc, tk, rs);
        end
        idle(3);
        check("strobe_count", 32'(en_count), 32'(m_commits));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
